// File: rtl/note_sequencer.sv
// note_sequencer: plays a latched 8-slot note pattern on piezo/LED with tick-timed note and gap phases.
// It also echoes keypad presses on the same outputs when no playback is running.
// Ports:
//   clk, reset      - clock; asynchronous active-high reset
//   i_pattern[31:0] - slot i note is i_pattern[4i+3:4i]
//   i_length[3:0]   - number of slots to play (0 = empty, >8 clamps to 8)
//   i_start         - one-cycle request to begin playback
//   i_abort         - stops any activity on the next cycle
//   i_key_valid     - one-cycle keypad strobe; i_key_code[3:0] is the pressed note
//   o_piezo_out     - note driven to the piezo (0 = silent)
//   o_led_out       - mirrors o_piezo_out
//   o_busy          - high while in NOTE or GAP
//   o_note_index    - slot currently playing
//   o_done          - one-cycle pulse when playback completes
//   o_key_accepted  - one-cycle pulse when a key is echoed
//   o_key_dropped   - one-cycle pulse when a key is refused
// Build option NOTE_SEQ_PAUSE_EN adds i_pause, which freezes timing and silences
// the piezo while playback is in NOTE or GAP.
module note_sequencer #(
    parameter int TICK_DIV   = 5000000,
    parameter int NOTE_TICKS = 2,
    parameter int GAP_TICKS  = 1,
    parameter int ECHO_TICKS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_pattern,
    input  logic [3:0]  i_length,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_code,
`ifdef NOTE_SEQ_PAUSE_EN
    input  logic        i_pause,
`endif
    output logic [3:0]  o_piezo_out,
    output logic [3:0]  o_led_out,
    output logic        o_busy,
    output logic [2:0]  o_note_index,
    output logic        o_done,
    output logic        o_key_accepted,
    output logic        o_key_dropped
);
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PMAX = (NOTE_TICKS > GAP_TICKS) ? ((NOTE_TICKS > ECHO_TICKS) ? NOTE_TICKS : ECHO_TICKS)
                                                   : ((GAP_TICKS > ECHO_TICKS) ? GAP_TICKS : ECHO_TICKS);
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [1:0] {IDLE, NOTE, GAP, ECHO} state_t;

    state_t      r_state, w_state_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic [PW-1:0] r_phase;
    logic [31:0] r_pattern;
    logic [3:0]  r_len;
    logic [2:0]  r_index, w_index_nxt, w_idx_inc;
    logic [3:0]  r_piezo, w_piezo_nxt, w_len_clamp, w_slot_cur, w_slot_inc;
    logic        r_busy, r_done, r_acc, r_drop;
    logic        w_done_nxt, w_acc_nxt, w_drop_nxt;
    logic        w_restart, w_enter, w_latch, w_tick, w_pause;

`ifdef NOTE_SEQ_PAUSE_EN
    assign w_pause = i_pause && (r_state == NOTE || r_state == GAP);
`else
    assign w_pause = 1'b0;
`endif

    assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_len_clamp = (i_length > 4'd8) ? 4'd8 : i_length;
    assign w_idx_inc   = r_index + 3'd1;
    assign w_slot_cur  = r_pattern[{r_index, 2'b00} +: 4];
    assign w_slot_inc  = r_pattern[{w_idx_inc, 2'b00} +: 4];

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_piezo_nxt = r_piezo;
        w_done_nxt  = 1'b0;
        w_acc_nxt   = 1'b0;
        w_drop_nxt  = 1'b0;
        w_restart   = 1'b0;
        w_enter     = 1'b0;
        w_latch     = 1'b0;
        if (i_abort) begin
            w_state_nxt = IDLE;
            w_index_nxt = 3'd0;
            w_piezo_nxt = 4'd0;
            w_drop_nxt  = i_key_valid;
            w_enter     = 1'b1;
        end else begin
            case (r_state)
                IDLE, ECHO: begin
                    if (i_start) begin
                        // start outranks a simultaneous key, which is refused
                        w_drop_nxt  = i_key_valid;
                        w_enter     = 1'b1;
                        w_index_nxt = 3'd0;
                        if (w_len_clamp != 4'd0) begin
                            w_state_nxt = NOTE;
                            w_piezo_nxt = i_pattern[3:0];
                            w_latch     = 1'b1;
                            w_restart   = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                            w_piezo_nxt = 4'd0;
                            w_done_nxt  = 1'b1;
                        end
                    end else if (i_key_valid) begin
                        w_state_nxt = ECHO;
                        w_piezo_nxt = i_key_code;
                        w_acc_nxt   = 1'b1;
                        w_restart   = 1'b1;
                        w_enter     = 1'b1;
                    end else if (r_state == ECHO && w_tick && r_phase == PW'(ECHO_TICKS - 1)) begin
                        w_state_nxt = IDLE;
                        w_piezo_nxt = 4'd0;
                        w_enter     = 1'b1;
                    end
                end
                NOTE: begin
                    w_drop_nxt = i_key_valid;
                    if (!w_pause && w_tick && r_phase == PW'(NOTE_TICKS - 1)) begin
                        w_state_nxt = GAP;
                        w_piezo_nxt = 4'd0;
                        w_enter     = 1'b1;
                    end else begin
                        w_piezo_nxt = w_pause ? 4'd0 : w_slot_cur;
                    end
                end
                default: begin
                    w_drop_nxt  = i_key_valid;
                    w_piezo_nxt = 4'd0;
                    if (!w_pause && w_tick && r_phase == PW'(GAP_TICKS - 1)) begin
                        w_enter = 1'b1;
                        if ({1'b0, r_index} == r_len - 4'd1) begin
                            w_state_nxt = IDLE;
                            w_index_nxt = 3'd0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = NOTE;
                            w_index_nxt = w_idx_inc;
                            w_piezo_nxt = w_slot_inc;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_phase    <= '0;
            r_pattern  <= '0;
            r_len      <= '0;
            r_index    <= '0;
            r_piezo    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_acc      <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_index    <= w_index_nxt;
            r_piezo    <= w_piezo_nxt;
            r_busy     <= (w_state_nxt == NOTE) || (w_state_nxt == GAP);
            r_done     <= w_done_nxt;
            r_acc      <= w_acc_nxt;
            r_drop     <= w_drop_nxt;
            r_tick_cnt <= w_restart ? '0 : w_pause ? r_tick_cnt : w_tick ? '0 : r_tick_cnt + 1'b1;
            r_phase    <= w_enter ? '0 : (w_tick && !w_pause) ? r_phase + 1'b1 : r_phase;
            if (w_latch) begin
                r_pattern <= i_pattern;
                r_len     <= w_len_clamp;
            end
        end
    end

    assign o_piezo_out    = r_piezo;
    assign o_led_out      = r_piezo;
    assign o_busy         = r_busy;
    assign o_note_index   = r_index;
    assign o_done         = r_done;
    assign o_key_accepted = r_acc;
    assign o_key_dropped  = r_drop;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed self-checking bench for note_sequencer with TICK_DIV=4, NOTE=2, GAP=1, ECHO=1.
module tb_note_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_pattern = '0;
    logic [3:0]  i_length = '0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_key_valid = 1'b0;
    logic [3:0]  i_key_code = '0;
`ifdef NOTE_SEQ_PAUSE_EN
    logic        i_pause = 1'b0;
`endif
    logic [3:0]  o_piezo_out, o_led_out;
    logic        o_busy, o_done, o_key_accepted, o_key_dropped;
    logic [2:0]  o_note_index;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    note_sequencer #(.TICK_DIV(4), .NOTE_TICKS(2), .GAP_TICKS(1), .ECHO_TICKS(1)) dut (
        .clk(clk),
        .reset(reset),
        .i_pattern(i_pattern),
        .i_length(i_length),
        .i_start(i_start),
        .i_abort(i_abort),
        .i_key_valid(i_key_valid),
        .i_key_code(i_key_code),
`ifdef NOTE_SEQ_PAUSE_EN
        .i_pause(i_pause),
`endif
        .o_piezo_out(o_piezo_out),
        .o_led_out(o_led_out),
        .o_busy(o_busy),
        .o_note_index(o_note_index),
        .o_done(o_done),
        .o_key_accepted(o_key_accepted),
        .o_key_dropped(o_key_dropped)
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_piezo_out, o_led_out, o_busy, o_note_index, o_done, o_key_accepted, o_key_dropped} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset outputs got %h want 0", {o_piezo_out, o_led_out, o_busy, o_note_index, o_done, o_key_accepted, o_key_dropped});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Starts playback and checks every cycle until done; a key with code 9 is pressed at cycle key_at.
    task automatic test_playback(input logic [31:0] pat, input logic [3:0] len, input int nslots, input int key_at);
        logic [3:0] exp_p;
        int         s, ph;
        i_pattern = pat;
        i_length  = len;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
        i_pattern = ~pat;
        for (int c = 0; c <= nslots * 12; c++) begin
            s  = c / 12;
            ph = c % 12;
            exp_p = (c == nslots * 12 || ph >= 8) ? 4'd0 : pat[4*s +: 4];
            n_checks++;
            if (o_piezo_out !== exp_p || o_led_out !== exp_p) begin
                n_fail++;
                $display("FAIL play piezo c=%0d got %h/%h want %h", c, o_piezo_out, o_led_out, exp_p);
            end
            n_checks++;
            if (o_busy !== (c < nslots * 12)) begin
                n_fail++;
                $display("FAIL play busy c=%0d got %b want %b", c, o_busy, c < nslots * 12);
            end
            n_checks++;
            if (o_note_index !== ((c < nslots * 12) ? 3'(s) : 3'd0)) begin
                n_fail++;
                $display("FAIL play index c=%0d got %0d want %0d", c, o_note_index, (c < nslots * 12) ? s : 0);
            end
            n_checks++;
            if (o_done !== (c == nslots * 12)) begin
                n_fail++;
                $display("FAIL play done c=%0d got %b want %b", c, o_done, c == nslots * 12);
            end
            n_checks++;
            if (o_key_dropped !== (c == key_at + 1) || o_key_accepted !== 1'b0) begin
                n_fail++;
                $display("FAIL play key c=%0d got drop=%b acc=%b want drop=%b acc=0", c, o_key_dropped, o_key_accepted, c == key_at + 1);
            end
            i_key_valid = (c == key_at);
            i_key_code  = 4'd9;
            i_start     = (c == 3);
            @(negedge clk);
        end
        i_key_valid = 1'b0;
        i_start     = 1'b0;
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL play after done got done=%b busy=%b want 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_length0();
        i_length = 4'd0;
        i_start  = 1'b1;
        @(negedge clk);
        i_start  = 1'b0;
        n_checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_piezo_out !== 4'd0) begin
            n_fail++;
            $display("FAIL len0 pulse got done=%b busy=%b piezo=%h want 1/0/0", o_done, o_busy, o_piezo_out);
        end
        @(negedge clk);
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len0 after got done=%b busy=%b want 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_echo(input int cycles);
        i_key_valid = 1'b1;
        i_key_code  = 4'd5;
        @(negedge clk);
        i_key_valid = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            n_checks++;
            if (o_piezo_out !== 4'd5 || o_led_out !== 4'd5 || o_busy !== 1'b0 || o_key_accepted !== (c == 0)) begin
                n_fail++;
                $display("FAIL echo c=%0d got piezo=%h led=%h busy=%b acc=%b want 5/5/0/%b", c, o_piezo_out, o_led_out, o_busy, o_key_accepted, c == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_echo_timeout();
        test_echo(4);
        n_checks++;
        if (o_piezo_out !== 4'd0 || o_key_accepted !== 1'b0) begin
            n_fail++;
            $display("FAIL echo end got piezo=%h acc=%b want 0/0", o_piezo_out, o_key_accepted);
        end
        @(negedge clk);
    endtask

    task automatic test_echo_preempt();
        test_echo(2);
        test_playback(32'h0000_4321, 4'd3, 3, -5);
    endtask

    task automatic test_abort();
        bit seen_done = 1'b0;
        i_pattern = 32'h0000_4321;
        i_length  = 4'd3;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++;
        if (o_piezo_out !== 4'd0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort pre-gap got piezo=%h busy=%b want 0/1", o_piezo_out, o_busy);
        end
        i_abort     = 1'b1;
        i_key_valid = 1'b1;
        i_start     = 1'b1;
        @(negedge clk);
        i_abort     = 1'b0;
        i_key_valid = 1'b0;
        i_start     = 1'b0;
        n_checks++;
        if (o_piezo_out !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_key_dropped !== 1'b1 || o_note_index !== 3'd0) begin
            n_fail++;
            $display("FAIL abort got piezo=%h busy=%b done=%b drop=%b idx=%0d want 0/0/0/1/0", o_piezo_out, o_busy, o_done, o_key_dropped, o_note_index);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            seen_done |= o_done | o_busy;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL abort quiet got done/busy=1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        i_pattern = 32'h0000_4321;
        i_length  = 4'd3;
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (o_piezo_out !== 4'd0 || o_led_out !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset mid got piezo=%h led=%h busy=%b done=%b want 0", o_piezo_out, o_led_out, o_busy, o_done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_playback(32'h0000_4321, 4'd3, 3, -5);
    endtask

    initial begin
        test_reset();
        test_playback(32'h0000_4321, 4'd3, 3, -5);
        test_length0();
        test_playback(32'h8765_4321, 4'd12, 8, -5);
        test_playback(32'h0000_4321, 4'd3, 3, 14);
        test_echo_timeout();
        test_echo_preempt();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
